// File: rtl/gmux_ctrl_pkg.sv
// Shared types and sizing helpers for the global clock mux select controller.
package gmux_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_SWITCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } gmux_state_e;

  function automatic int unsigned gmux_clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Grant index width: at least one bit even for a single requester.
  function automatic int unsigned gmux_id_w(input int unsigned n);
    return (gmux_clog2(n) < 1) ? 1 : gmux_clog2(n);
  endfunction

  function automatic int unsigned gmux_cnt_w(input int unsigned drain, input int unsigned settle);
    return gmux_clog2((drain > settle) ? drain : settle) + 1;
  endfunction

endpackage

// File: rtl/gmux_sel_ctrl_if.sv
// Requester and mux-control signal bundle for gmux_sel_ctrl.
interface gmux_sel_ctrl_if
  import gmux_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  localparam int IW = gmux_id_w(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_sel;
  logic [NUM_REQ-1:0] ack;
  logic [IW-1:0]      gnt_id;
  logic               busy;
  logic               gate_en;
  logic               is0;

  modport master (
    output req, req_sel,
    input  ack, gnt_id, busy, gate_en, is0
  );

  modport slave (
    input  req, req_sel,
    output ack, gnt_id, busy, gate_en, is0
  );
endinterface

// File: rtl/gmux_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module gmux_rr_arb
  import gmux_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = gmux_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [IW-1:0]      o_gnt_id,
  output logic               o_valid
);

  int unsigned w_idx;

  // Walk from the farthest offset back to the pointer so the nearest hit wins.
  always_comb begin
    o_gnt_id = '0;
    o_valid  = 1'b0;
    w_idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[w_idx]) begin
        o_gnt_id = IW'(w_idx);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gmux_sel_ctrl.sv
// Round-robin sequencer for the IS0 select of a glitch-free global clock mux:
// gate downstream enable, drain, flip IS0, settle, then acknowledge.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates when any REQ is set
// DRAIN  | GATE_EN low, old source still selected, DRAIN_CYC cycles
// SWITCH | GATE_EN low, IS0 takes the latched select on exit
// SETTLE | GATE_EN low, new source settling, SETTLE_CYC cycles
// DONE   | one-cycle ACK to the granted requester, GATE_EN back high
module gmux_sel_ctrl
  import gmux_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DRAIN_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter bit RESET_SEL  = 1'b0
) (
  input logic              i_clk,
  input logic              i_rst,
  gmux_sel_ctrl_if.slave   bus
);

  localparam int IW = gmux_id_w(NUM_REQ);
  localparam int CW = gmux_cnt_w(DRAIN_CYC, SETTLE_CYC);
  localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(NUM_REQ - 1);

  gmux_state_e          r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_gnt_id;
  logic                 r_sel;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_busy;
  logic                 r_gate_en;
  logic                 r_is0;

  logic [IW-1:0]        w_arb_id;
  logic                 w_arb_vld;
  logic [IW-1:0]        w_ptr_nxt;
  logic                 w_arb_sel;

  gmux_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_gnt_id (w_arb_id),
    .o_valid  (w_arb_vld)
  );

  assign w_ptr_nxt = (w_arb_id == LAST_ID) ? '0 : w_arb_id + 1'b1;
  assign w_arb_sel = bus.req_sel[w_arb_id];

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IW-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_gnt_id  <= '0;
      r_sel     <= RESET_SEL;
      r_ack     <= '0;
      r_busy    <= 1'b0;
      r_gate_en <= 1'b1;
      r_is0     <= RESET_SEL;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_vld) begin
            r_gnt_id <= w_arb_id;
            r_sel    <= w_arb_sel;
            r_ptr    <= w_ptr_nxt;
            r_busy   <= 1'b1;
            if (w_arb_sel != r_is0) begin
              r_state   <= ST_DRAIN;
              r_cnt     <= DRAIN_LD;
              r_gate_en <= 1'b0;
            end else begin
              // Select already matches: acknowledge without touching the clock.
              r_state <= ST_DONE;
              r_ack   <= f_onehot(w_arb_id);
            end
          end
        end
        ST_DRAIN: begin
          if (r_cnt == '0) begin
            r_state <= ST_SWITCH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SWITCH: begin
          r_is0   <= r_sel;
          r_state <= ST_SETTLE;
          r_cnt   <= SETTLE_LD;
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state   <= ST_DONE;
            r_gate_en <= 1'b1;
            r_ack     <= f_onehot(r_gnt_id);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_gate_en <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ack     = r_ack;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = r_busy;
  assign bus.gate_en = r_gate_en;
  assign bus.is0     = r_is0;

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// Bench for gmux_sel_ctrl: directed scenarios plus random requesters, checked
// every cycle against a timeline model keyed on cycles elapsed since grant.
module tb_gmux_sel_ctrl;
  import gmux_ctrl_pkg::*;

  localparam int NR = 2;
  localparam int DC = 4;
  localparam int SC = 8;
  localparam bit RS = 1'b0;
  localparam int SW_LEN = DC + SC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gmux_sel_ctrl_if #(.NUM_REQ(NR)) bus ();

  gmux_sel_ctrl #(
    .NUM_REQ    (NR),
    .DRAIN_CYC  (DC),
    .SETTLE_CYC (SC),
    .RESET_SEL  (RS)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: only grant bookkeeping and elapsed-cycle timing.
  int          edge_n = 0;
  bit          m_act  = 1'b0;
  int          m_g    = 0;
  bit          m_sw   = 1'b0;
  int          m_id   = 0;
  bit          m_sel  = 1'b0;
  bit          m_is0  = RS;
  int          m_ptr  = 0;
  logic [NR-1:0] e_ack;
  logic        e_busy;
  logic        e_gate;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  // d counts cycles since the grant edge: d=1 is the cycle right after the grant.
  task automatic model_edge();
    int d;
    edge_n++;
    if (rst) begin
      m_act = 1'b0;
      m_ptr = 0;
      m_id  = 0;
      m_is0 = RS;
    end else if (!m_act) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (bus.req[idx]) begin
          m_act = 1'b1;
          m_g   = edge_n;
          m_id  = idx;
          m_sel = bus.req_sel[idx];
          m_sw  = (m_sel != m_is0);
          m_ptr = (idx + 1) % NR;
          break;
        end
      end
    end else if (edge_n + 1 - m_g == (m_sw ? SW_LEN : 1) + 1) begin
      m_act = 1'b0;
    end
    d = edge_n + 1 - m_g;
    if (m_act && m_sw && d == DC + 2) m_is0 = m_sel;
    e_ack  = '0;
    e_busy = m_act;
    e_gate = 1'b1;
    if (m_act) begin
      if (m_sw) begin
        e_gate = !(d >= 1 && d <= DC + SC + 1);
        if (d == SW_LEN) e_ack[m_id] = 1'b1;
      end else if (d == 1) begin
        e_ack[m_id] = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack",     32'(bus.ack),     32'(e_ack));
    chk("gnt_id",  32'(bus.gnt_id),  32'(m_id));
    chk("busy",    32'(bus.busy),    32'(e_busy));
    chk("gate_en", 32'(bus.gate_en), 32'(e_gate));
    chk("is0",     32'(bus.is0),     32'(m_is0));
    @(negedge clk);
  endtask

  // Requesters drop REQ once the model says they were acknowledged.
  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      cyc();
      rst = rnd && ($urandom_range(299) == 0);
      for (int j = 0; j < NR; j++) begin
        if (e_ack[j]) begin
          bus.req[j] = 1'b0;
        end else if (rnd) begin
          if (!bus.req[j] && $urandom_range(3) == 0) begin
            bus.req[j]     = 1'b1;
            bus.req_sel[j] = 1'($urandom_range(1));
          end else if (bus.req[j] && $urandom_range(49) == 0) begin
            bus.req[j] = 1'b0;
          end else if ($urandom_range(9) == 0) begin
            bus.req_sel[j] = ~bus.req_sel[j];
          end
        end
      end
    end
  endtask

  initial begin
    int lat;
    bus.req     = '0;
    bus.req_sel = '0;
    rst         = 1'b1;
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_is0",    32'(bus.is0),     32'(RS));
    chk("rst_gate",   32'(bus.gate_en), 32'd1);
    chk("rst_busy",   32'(bus.busy),    32'd0);
    chk("rst_ack",    32'(bus.ack),     32'd0);
    chk("rst_gnt_id", 32'(bus.gnt_id),  32'd0);

    // Switching request from requester 0.
    bus.req[0]     = 1'b1;
    bus.req_sel[0] = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      lat++;
      if (bus.ack != '0) break;
    end
    bus.req[0] = 1'b0;
    chk("ack_latency", 32'(lat), 32'(SW_LEN));
    cyc();

    // No-op request: select already 1.
    bus.req[1]     = 1'b1;
    bus.req_sel[1] = 1'b1;
    cyc();
    chk("noop_ack",  32'(bus.ack),     32'h2);
    chk("noop_gate", 32'(bus.gate_en), 32'd1);
    bus.req[1] = 1'b0;
    run(3, 1'b0);

    // Simultaneous requests after reset, then again to exercise pointer wrap.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.req     = 2'b11;
    bus.req_sel = 2'b10;
    run(40, 1'b0);
    bus.req     = 2'b11;
    bus.req_sel = 2'b00;
    run(60, 1'b0);

    // Reset during SETTLE aborts the sequence with no ACK.
    bus.req[0]     = 1'b1;
    bus.req_sel[0] = ~m_is0;
    repeat (10) cyc();
    rst     = 1'b1;
    bus.req = '0;
    cyc();
    chk("abort_is0",  32'(bus.is0),     32'(RS));
    chk("abort_busy", 32'(bus.busy),    32'd0);
    rst = 1'b0;
    run(30, 1'b0);

    // Requester withdraws during DRAIN; sequence still completes.
    bus.req[0]     = 1'b1;
    bus.req_sel[0] = ~m_is0;
    cyc();
    cyc();
    bus.req[0] = 1'b0;
    run(25, 1'b0);

    run(3000, 1'b1);
    rst = 1'b0;
    run(5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
